// File: rtl/led_matrix_scanner_if.sv
// Host write port, scan clock input and matrix pin drive for led_matrix_scanner.
interface led_matrix_scanner_if;
    logic       scan_clk;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       commit;
    logic [7:0] row_n;
    logic [7:0] col;
    logic       frame_start;
    logic       swap_done;
    logic       busy;

    modport master (
        output scan_clk, wr_en, wr_row, wr_data, commit,
        input  row_n, col, frame_start, swap_done, busy
    );

    modport slave (
        input  scan_clk, wr_en, wr_row, wr_data, commit,
        output row_n, col, frame_start, swap_done, busy
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Scans a double-buffered 8x8 frame one row per scan_clk rise; rows change 2 clk after the rise is sampled.
// Define LED_SCAN_BLANK_EN to keep outputs dark for BLANK_CYCLES clk after every row step.
module led_matrix_scanner #(
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    led_matrix_scanner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t     state_q, state_d;
    logic       s1, s2, s3;
    logic       step, wrap;
    logic [2:0] row_idx;
    logic [7:0] shadow [8];
    logic [7:0] active [8];
    logic       busy_q, frame_start_q, swap_done_q;
    logic [7:0] row_drv, col_drv;

    if (BLANK_CYCLES > 255) begin : g_blank_range
        $error("BLANK_CYCLES must be within 0..255");
    end

    assign step = s2 & ~s3;
    assign wrap = step && (row_idx == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.scan_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A commit on the swap cycle wins over the clear so the next frame swaps again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_idx       <= 3'd7;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            swap_done_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 8'h00;
                active[i] <= 8'h00;
            end
        end else begin
            if (step)
                row_idx <= (row_idx == 3'd7) ? 3'd0 : row_idx + 3'd1;
            frame_start_q <= wrap;
            swap_done_q   <= wrap && busy_q;
            if (bus.commit)
                busy_q <= 1'b1;
            else if (wrap)
                busy_q <= 1'b0;
            if (wrap && busy_q)
                for (int i = 0; i < 8; i++)
                    active[i] <= shadow[i];
            if (bus.wr_en)
                shadow[bus.wr_row] <= bus.wr_data;
        end
    end

`ifdef LED_SCAN_BLANK_EN
    logic [7:0] blank_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            blank_cnt <= 8'd0;
        else if (step)
            blank_cnt <= 8'(BLANK_CYCLES);
        else if (blank_cnt != 8'd0)
            blank_cnt <= blank_cnt - 8'd1;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // IDLE keeps the matrix dark from reset until the first row step.
    always_comb begin
        state_d = state_q;
        row_drv = 8'hFF;
        col_drv = 8'h00;
        case (state_q)
            DRIVE: begin
                row_drv = ~(8'd1 << row_idx);
                col_drv = active[row_idx];
            end
            default: ;
        endcase
`ifdef LED_SCAN_BLANK_EN
        if (step)
            state_d = (BLANK_CYCLES != 0) ? BLANK : DRIVE;
        else if (state_q == BLANK && blank_cnt <= 8'd1)
            state_d = DRIVE;
`else
        if (step)
            state_d = DRIVE;
`endif
    end

    assign bus.row_n       = row_drv;
    assign bus.col         = col_drv;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_done   = swap_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed, table-driven bench for led_matrix_scanner with BLANK_CYCLES = 4.
module tb_led_matrix_scanner;
`ifdef LED_SCAN_BLANK_EN
    localparam int BL = 4;
`else
    localparam int BL = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    led_matrix_scanner_if bus ();

    led_matrix_scanner #(.BLANK_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] e_row_n;
        logic [7:0] e_col;
        logic       e_fs;
        logic       e_sd;
        logic       e_busy;
    } vec_t;

    vec_t scan_tbl [9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One scan_clk rise; the optional write/commit lands on the step cycle itself.
    task automatic do_step(input string nm, input vec_t v,
                           input logic ev_wr, input logic [2:0] ev_row,
                           input logic [7:0] ev_dat, input logic ev_commit);
        bus.scan_clk = 1'b1;
        tick;
        tick;
        bus.wr_en   = ev_wr;
        bus.wr_row  = ev_row;
        bus.wr_data = ev_dat;
        bus.commit  = ev_commit;
        tick;
        bus.wr_en  = 1'b0;
        bus.commit = 1'b0;
        check({nm, ".frame_start"}, 32'(bus.frame_start), 32'(v.e_fs));
        check({nm, ".swap_done"}, 32'(bus.swap_done), 32'(v.e_sd));
        for (int c = 0; c <= BL; c++) begin
            check({nm, ".row_n"}, 32'(bus.row_n), (c < BL) ? 32'hFF : 32'(v.e_row_n));
            check({nm, ".col"}, 32'(bus.col), (c < BL) ? 32'h00 : 32'(v.e_col));
            tick;
        end
        check({nm, ".fs_pulse"}, 32'(bus.frame_start), 32'h0);
        check({nm, ".sd_pulse"}, 32'(bus.swap_done), 32'h0);
        check({nm, ".busy"}, 32'(bus.busy), 32'(v.e_busy));
        check({nm, ".row_hold"}, 32'(bus.row_n), 32'(v.e_row_n));
        bus.scan_clk = 1'b0;
        repeat (90) tick;
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = r;
        bus.wr_data = d;
        tick;
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_commit;
        bus.commit = 1'b1;
        tick;
        bus.commit = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] rn, input logic [7:0] c,
                                input logic fs, input logic sd, input logic b);
        vec_t v;
        v.e_row_n = rn;
        v.e_col   = c;
        v.e_fs    = fs;
        v.e_sd    = sd;
        v.e_busy  = b;
        return v;
    endfunction

    // Walks rows 1..7 with the given columns of the active frame.
    task automatic walk_rows(input string nm, input logic [7:0] cols [8], input logic b);
        logic [7:0] rn [8];
        rn = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        for (int r = 1; r < 8; r++)
            do_step($sformatf("%s_r%0d", nm, r), mk(rn[r], cols[r], 1'b0, 1'b0, b),
                    1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] cols [8];
        checks   = 0;
        failures = 0;

        scan_tbl[0] = mk(8'hFE, 8'h01, 1'b1, 1'b1, 1'b0);
        scan_tbl[1] = mk(8'hFD, 8'h02, 1'b0, 1'b0, 1'b0);
        scan_tbl[2] = mk(8'hFB, 8'h04, 1'b0, 1'b0, 1'b0);
        scan_tbl[3] = mk(8'hF7, 8'h08, 1'b0, 1'b0, 1'b0);
        scan_tbl[4] = mk(8'hEF, 8'h10, 1'b0, 1'b0, 1'b0);
        scan_tbl[5] = mk(8'hDF, 8'h20, 1'b0, 1'b0, 1'b0);
        scan_tbl[6] = mk(8'hBF, 8'h40, 1'b0, 1'b0, 1'b0);
        scan_tbl[7] = mk(8'h7F, 8'h80, 1'b0, 1'b0, 1'b0);
        scan_tbl[8] = mk(8'hFE, 8'h01, 1'b1, 1'b0, 1'b0);

        rst          = 1'b0;
        bus.scan_clk = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_row   = 3'd0;
        bus.wr_data  = 8'h00;
        bus.commit   = 1'b0;

        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++) begin
            bus.scan_clk = i[0];
            bus.commit   = ~i[0];
            bus.wr_en    = 1'b1;
            bus.wr_data  = 8'hFF;
            tick;
            check("rst.row_n", 32'(bus.row_n), 32'hFF);
            check("rst.col", 32'(bus.col), 32'h00);
            check("rst.fs", 32'(bus.frame_start), 32'h0);
            check("rst.sd", 32'(bus.swap_done), 32'h0);
            check("rst.busy", 32'(bus.busy), 32'h0);
        end
        bus.scan_clk = 1'b0;
        bus.commit   = 1'b0;
        bus.wr_en    = 1'b0;
        tick;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("idle.row_n", 32'(bus.row_n), 32'hFF);
            check("idle.col", 32'(bus.col), 32'h00);
            check("idle.fs", 32'(bus.frame_start), 32'h0);
            check("idle.busy", 32'(bus.busy), 32'h0);
        end

        // Load diagonal pattern, commit, scan a full frame plus the wrap.
        for (int r = 0; r < 8; r++)
            write_row(3'(r), 8'(1 << r));
        pulse_commit;
        check("commit.busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 9; i++)
            do_step($sformatf("scan%0d", i), scan_tbl[i], 1'b0, 3'd0, 8'h00, 1'b0);

        // Write on the swap cycle: swap takes the old shadow row 0.
        cols = '{8'h3C, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        write_row(3'd0, 8'h3C);
        pulse_commit;
        walk_rows("coll", cols, 1'b1);
        do_step("coll_wrap", mk(8'hFE, 8'h3C, 1'b1, 1'b1, 1'b0), 1'b1, 3'd0, 8'hAA, 1'b0);
        walk_rows("coll2", cols, 1'b0);
        pulse_commit;
        do_step("coll2_wrap", mk(8'hFE, 8'hAA, 1'b1, 1'b1, 1'b0), 1'b0, 3'd0, 8'h00, 1'b0);

        // Commit on the wrapping step with busy low: swap deferred one frame.
        cols[0] = 8'hAA;
        write_row(3'd0, 8'h0F);
        walk_rows("cw", cols, 1'b0);
        do_step("cw_wrap", mk(8'hFE, 8'hAA, 1'b1, 1'b0, 1'b1), 1'b0, 3'd0, 8'h00, 1'b1);
        walk_rows("cw2", cols, 1'b1);
        do_step("cw2_wrap", mk(8'hFE, 8'h0F, 1'b1, 1'b1, 1'b0), 1'b0, 3'd0, 8'h00, 1'b0);

        // Async reset while row 3 is being blanked, with a commit pending.
        cols[0] = 8'h0F;
        pulse_commit;
        do_step("ar_r1", mk(8'hFD, 8'h02, 1'b0, 1'b0, 1'b1), 1'b0, 3'd0, 8'h00, 1'b0);
        do_step("ar_r2", mk(8'hFB, 8'h04, 1'b0, 1'b0, 1'b1), 1'b0, 3'd0, 8'h00, 1'b0);
        bus.scan_clk = 1'b1;
        repeat (4) tick;
        rst = 1'b0;
        #1;
        check("ar.row_n", 32'(bus.row_n), 32'hFF);
        check("ar.col", 32'(bus.col), 32'h00);
        check("ar.busy", 32'(bus.busy), 32'h0);
        bus.scan_clk = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        repeat (5) tick;
        check("ar.idle_row_n", 32'(bus.row_n), 32'hFF);
        do_step("ar_first", mk(8'hFE, 8'h00, 1'b1, 1'b0, 1'b0), 1'b0, 3'd0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Consumes the slow scan clock produced by the LED-matrix frequency divider and drives an 8x8 LED matrix, one row at a time. It holds a double-buffered 8x8 frame. The host writes rows into a shadow buffer, and the shadow is copied into the active buffer only at a frame boundary. The block sits between the divider and the matrix row/column pins.

## Interface
- BLANK_CYCLES, 16: clk cycles the outputs stay dark after each row step (ghost suppression); 0..255.
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset, asynchronous, active-low (low = reset).
- scan_clk  in  1  divided clock from the frequency divider, treated as an asynchronous level; each rising edge advances one row.
- wr_en  in  1  shadow-buffer write strobe.
- wr_row  in  3  shadow row index for the write.
- wr_data  in  8  column pattern for that row; bit i lights column i.
- commit  in  1  one-cycle pulse requesting that shadow be copied to active at the next frame start.
- row_n  out  8  row drive, one-hot active-low; bit r low = row r on.
- col  out  8  column drive, active-high.
- frame_start  out  1  one-cycle pulse when the scan wraps to row 0.
- swap_done  out  1  one-cycle pulse when shadow has been copied to active.
- busy  out  1  high while a commit is pending.

## Operation
- Reset state:
  - row_n = 8'hFF; col = 8'h00.
  - frame_start, swap_done, busy = 0.
  - row_idx = 7, so the first step lands on row 0.
  - Both buffers are cleared to 0; synchronizer and blank counter are cleared.
- Step detection:
  - scan_clk passes through a 2-flop synchronizer (s1, s2) and a delay flop (s3).
  - step = s2 & ~s3. Only rising edges count; level and falling edges are ignored.
- On step:
  - row_idx <= (row_idx == 7) ? 0 : row_idx + 1.
  - The blank counter loads BLANK_CYCLES.
- Output states (two):
  - BLANK: blank counter is nonzero; row_n = FF, col = 00; the counter decrements each cycle.
  - DRIVE: row_n = ~(1 << row_idx); col = active[row_idx].
- Step during BLANK: row_idx advances again and the counter reloads.
- Frame start: on a step that wraps 7 -> 0, frame_start pulses. If busy = 1 on that same cycle:
  - active <= shadow, copying all 8 rows at once;
  - busy clears and swap_done pulses in the same cycle as frame_start.
- Writes: when wr_en = 1, shadow[wr_row] <= wr_data. Writes never touch the active buffer directly.
- Commit: busy is set the cycle after commit. Repeated commits while busy are absorbed, producing a single swap.

## Timing
- A scan_clk rise is first sampled at clk edge N. s2 is high at N+1, step is asserted in the cycle after N+1, and row_idx / frame_start / swap_done update at edge N+2.
- row_n/col go dark at edge N+2 and show the new row at edge N+2+BLANK_CYCLES.
- With BLANK_CYCLES = 0, the new row drives directly at N+2.
- Simultaneous wr_en and swap in one cycle: the copy uses shadow contents from before that cycle. The write lands in shadow only and appears in the following swap.
- Simultaneous commit and wrapping step (busy = 0): no swap this frame. busy rises next cycle and the swap happens at the next wrap.
- Commit in the same cycle as the swap cycle (busy = 1): the current swap completes, swap_done pulses, and busy remains 1 for the next frame.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Pending commits and buffer contents are lost.
- Minimum supported scan_clk high and low time: 2 clk cycles each. Shorter pulses may be missed, and that is not an error.

## Configuration
- LED_SCAN_BLANK_EN defined: BLANK behaviour as specified, using BLANK_CYCLES.
- LED_SCAN_BLANK_EN undefined:
  - the blank counter and BLANK state are not built; BLANK_CYCLES is ignored;
  - outputs switch straight to the new row at edge N+2;
  - all other behaviour is unchanged.

## Test plan
- Reset: hold rst = 0 with toggling inputs. Require row_n = FF, col = 00, frame_start = swap_done = busy = 0. Release and hold scan_clk low: outputs stay unchanged.
- Scan sequence: write shadow rows 0..7 = 8'h01,8'h02,...,8'h80, then commit. Apply 8 scan_clk rises, 100 clk apart, with BLANK_CYCLES = 4. Require:
  - swap_done with frame_start on the first step;
  - row_n = FE,FD,...,7F with col = 01,02,...,80;
  - each row dark for exactly 4 clk before driving.
- Wrap: continue to the 9th rise. Require row_idx back to 0, row_n = FE, frame_start = 1 for one cycle, and no swap_done (busy = 0).
- Write/swap collision: with busy = 1, drive wr_en (row 0, 8'hAA) on the wrapping step cycle. Require active row 0 = old shadow value. After the next commit and wrap, require col = AA on row 0.
- Commit on wrap cycle: pulse commit exactly on the step 7 -> 0 with busy = 0. Require no swap_done that frame, busy = 1, and swap_done on the following wrap.
- Async reset mid-blank: assert rst during BLANK on row 3. Require immediate row_n = FF, col = 00, busy = 0. After release, the first step drives row 0 with frame_start.
